prover_shuffle_drain: RTL

//  Consumer end of the prover_shuffle_early handshake. Restarts the shuffle, captures each

---
 rtl/prover_shuffle_drain_pkg.sv | 26 ++
 rtl/prover_shuffle_pair_mux.sv | 40 ++++
 rtl/prover_shuffle_drain.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/prover_shuffle_drain_pkg.sv
// Shared definitions for the shuffle drain: field width, FSM states, debug view
// and the per-round beat count used by the datapath and its checkers.
package prover_shuffle_drain_pkg;

  localparam int F_NBITS = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESTART = 2'd1,
    S_WAIT    = 2'd2,
    S_STREAM  = 2'd3
  } state_t;

  typedef struct packed {
    state_t state;
    logic   shuf_ready;
  } dbg_t;

  // Beats needed to drain round r: pairs = 2^nvb >> (r+1), packed 2^npb per beat, at least one.
  function automatic int bcount(input int r, input int nvb, input int npb);
    int p;
    p = (1 << nvb) >> (r + 1);
    return ((p >> npb) < 1) ? 1 : (p >> npb);
  endfunction

endpackage

// File: rtl/prover_shuffle_pair_mux.sv
// Combinational lane select: picks the (lo,hi) pairs of one output beat out of the
// captured value window, for a given round and beat index.
module prover_shuffle_pair_mux
  import prover_shuffle_drain_pkg::*;
#(
  parameter int nValBits = 4,
  parameter int nParBits = 1
) (
  input  logic [(1<<nValBits)*F_NBITS-1:0] buf_i,
  input  logic [nValBits-1:0]              round_i,
  input  logic [nValBits-1:0]              beat_i,
  output logic [(1<<nParBits)*F_NBITS-1:0] lo_o,
  output logic [(1<<nParBits)*F_NBITS-1:0] hi_o,
  output logic [(1<<nParBits)-1:0]         vld_o
);

  localparam int NV = 1 << nValBits;
  localparam int NL = 1 << nParBits;

  int k;
  int p;

  always_comb begin
    lo_o  = '0;
    hi_o  = '0;
    vld_o = '0;
    k     = 0;
    p     = NV >> (int'(round_i) + 1);
    for (int j = 0; j < NL; j++) begin
      k = (int'(beat_i) << nParBits) + j;
      // Lanes past the last pair of the round stay zero.
      if (k < p) begin
        vld_o[j]                  = 1'b1;
        lo_o[j*F_NBITS +: F_NBITS] = buf_i[(2*k)*F_NBITS +: F_NBITS];
        hi_o[j*F_NBITS +: F_NBITS] = buf_i[(2*k+1)*F_NBITS +: F_NBITS];
      end
    end
  end

endmodule

// File: rtl/prover_shuffle_drain.sv
// Consumer of the shuffle: restarts it, captures each round's window and streams it out
// as pair lanes over valid/ready, advancing the shuffle only once the window is drained.
module prover_shuffle_drain
  import prover_shuffle_drain_pkg::*;
#(
  parameter int nValBits = 4,
  parameter int nParBits = 1
) (
  input  logic                              clk,
  input  logic                              rstb,
  input  logic                              start,
  output logic                              shuf_restart,
  output logic                              shuf_en,
  input  logic                              shuf_ready,
  input  logic                              shuf_ready_pulse,
  input  logic [(1<<nValBits)*F_NBITS-1:0]  vals_in,
  output logic [(1<<nParBits)*F_NBITS-1:0]  out_lo,
  output logic [(1<<nParBits)*F_NBITS-1:0]  out_hi,
  output logic [(1<<nParBits)-1:0]          out_lane_vld,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [nValBits-1:0]               round,
  output logic                              busy,
  output logic                              done,
  output dbg_t                              dbg
);

  localparam int NV = 1 << nValBits;
  localparam int NL = 1 << nParBits;

  // Handshake: a beat transfers on a rising clk edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, every beat output holds its value.

  state_t                  state_q, state_d;
  logic [nValBits-1:0]     round_q, round_d;
  logic [nValBits-1:0]     beat_q, beat_d;
  logic [NV*F_NBITS-1:0]   vbuf_q, vbuf_d;
  logic                    valid_q, valid_d;
  logic                    restart_q, restart_d;
  logic                    en_q, en_d;
  logic                    done_q, done_d;
  logic                    last_q, last_d;
  logic                    busy_q;
  logic                    shuf_ready_q;
  logic [NL*F_NBITS-1:0]   lo_q, hi_q, mux_lo, mux_hi;
  logic [NL-1:0]           vld_q, mux_vld;
  logic                    beat_last;

  assign beat_last = (int'(beat_q) == bcount(int'(round_q), nValBits, nParBits) - 1);
  assign last_d    = valid_d && (int'(beat_d) == bcount(int'(round_d), nValBits, nParBits) - 1);

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    beat_d    = beat_q;
    vbuf_d    = vbuf_q;
    valid_d   = valid_q;
    restart_d = 1'b0;
    en_d      = 1'b0;
    done_d    = 1'b0;
    // start overrides everything, including an accept of the final beat.
    if (start) begin
      state_d   = S_RESTART;
      restart_d = 1'b1;
      valid_d   = 1'b0;
      round_d   = '0;
      beat_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_RESTART: state_d = S_WAIT;
        S_WAIT: begin
          if (shuf_ready_pulse) begin
            vbuf_d  = vals_in;
            valid_d = 1'b1;
            state_d = S_STREAM;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (!beat_last) begin
              beat_d = beat_q + 1'b1;
            end else if (int'(round_q) < nValBits - 1) begin
              en_d    = 1'b1;
              round_d = round_q + 1'b1;
              beat_d  = '0;
              valid_d = 1'b0;
              state_d = S_WAIT;
            end else begin
              done_d  = 1'b1;
              round_d = '0;
              beat_d  = '0;
              valid_d = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Lanes are computed from next-state values so the registered beat lines up with out_valid.
  prover_shuffle_pair_mux #(
    .nValBits (nValBits),
    .nParBits (nParBits)
  ) u_pair_mux (
    .buf_i   (vbuf_d),
    .round_i (round_d),
    .beat_i  (beat_d),
    .lo_o    (mux_lo),
    .hi_o    (mux_hi),
    .vld_o   (mux_vld)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= S_IDLE;
      round_q      <= '0;
      beat_q       <= '0;
      vbuf_q       <= '0;
      valid_q      <= 1'b0;
      restart_q    <= 1'b0;
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      shuf_ready_q <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
      vld_q        <= '0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      beat_q       <= beat_d;
      vbuf_q       <= vbuf_d;
      valid_q      <= valid_d;
      restart_q    <= restart_d;
      en_q         <= en_d;
      done_q       <= done_d;
      last_q       <= last_d;
      busy_q       <= (state_d != S_IDLE);
      shuf_ready_q <= shuf_ready;
      lo_q         <= valid_d ? mux_lo : '0;
      hi_q         <= valid_d ? mux_hi : '0;
      vld_q        <= valid_d ? mux_vld : '0;
    end
  end

  assign shuf_restart = restart_q;
  assign shuf_en      = en_q;
  assign out_valid    = valid_q;
  assign out_last     = last_q;
  assign out_lo       = lo_q;
  assign out_hi       = hi_q;
  assign out_lane_vld = vld_q;
  assign round        = round_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg          = '{state: state_q, shuf_ready: shuf_ready_q};

endmodule
